// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures imem data into the IF/ID
// register, and handles decode stalls and taken-branch redirects with bubbles.
module fetch_stage #(
    parameter int                   PC_WIDTH    = 8,
    parameter int                   INSTR_WIDTH = 11,
    parameter int                   RESET_PC    = 0,
    parameter int                   PC_LIMIT    = 128,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 11'b000_0000_0000,
    parameter int                   CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic                   id_valid,
    output logic [CNT_WIDTH-1:0]   issued_count
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC_LIMIT is a power of two, so masking implements both wrap and target clamping.
    localparam logic [PC_WIDTH-1:0]  PC_MASK  = PC_WIDTH'(PC_LIMIT - 1);
    localparam logic [PC_WIDTH-1:0]  PC_INIT  = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0]  PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH-1:0]  PC_ZERO  = {PC_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                   state_r, state_s;
    logic [PC_WIDTH-1:0]      pc_r, pc_s;
    logic [INSTR_WIDTH-1:0]   id_instr_r, id_instr_s;
    logic [PC_WIDTH-1:0]      id_pc_r, id_pc_s;
    logic                     id_valid_r, id_valid_s;
    logic [CNT_WIDTH-1:0]     count_r, count_s;

    // Next-state and next-value logic for the BOOT/RUN controller and IF/ID register.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        id_instr_s = id_instr_r;
        id_pc_s    = id_pc_r;
        id_valid_s = id_valid_r;
        count_s    = count_r;
        case (state_r)
            BOOT: begin
                state_s = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    // Redirect wins over stall; Instr is not sampled here.
                    pc_s       = branch_target & PC_MASK;
                    id_instr_s = NOP_INSTR;
                    id_pc_s    = PC_ZERO;
                    id_valid_s = 1'b0;
                end else if (stall) begin
                    pc_s       = pc_r;
                    id_instr_s = id_instr_r;
                    id_pc_s    = id_pc_r;
                    id_valid_s = id_valid_r;
                end else begin
                    pc_s       = (pc_r + PC_ONE) & PC_MASK;
                    id_instr_s = Instr;
                    id_pc_s    = pc_r;
                    id_valid_s = 1'b1;
                    if (count_r != CNT_MAX) begin
                        count_s = count_r + CNT_ONE;
                    end else begin
                        count_s = count_r;
                    end
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= BOOT;
            pc_r       <= PC_INIT & PC_MASK;
            id_instr_r <= NOP_INSTR;
            id_pc_r    <= PC_ZERO;
            id_valid_r <= 1'b0;
            count_r    <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            id_instr_r <= id_instr_s;
            id_pc_r    <= id_pc_s;
            id_valid_r <= id_valid_s;
            count_r    <= count_s;
        end
    end

    assign PC           = pc_r;
    assign id_instr     = id_instr_r;
    assign id_pc        = id_pc_r;
    assign id_valid     = id_valid_r;
    assign issued_count = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 128-word imem model
// where imem[i] = i + 1.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [10:0] instr;
    logic [7:0]  pc;
    logic [10:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_valid;
    logic [7:0]  issued_count;

    logic [10:0] imem [0:127];
    int          n_cmp;
    int          n_fail;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .Instr        (instr),
        .PC           (pc),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .issued_count (issued_count)
    );

    assign instr = imem[pc[6:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc cyc%0d got %h want 00", i, pc); end
            n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc%0d got %b want 0", i, id_valid); end
        end
        n_cmp++; if (id_instr !== 11'h000) begin n_fail++; $display("FAIL reset_instr got %h want 000", id_instr); end
        n_cmp++; if (issued_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", issued_count); end
        reset = 1'b0;
        step();
        n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL boot_pc got %h want 00", pc); end
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", id_valid); end
        step();
        n_cmp++; if (id_instr !== 11'h001) begin n_fail++; $display("FAIL first_instr got %h want 001", id_instr); end
        n_cmp++; if (id_pc !== 8'h00) begin n_fail++; $display("FAIL first_idpc got %h want 00", id_pc); end
        n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", id_valid); end
        n_cmp++; if (pc !== 8'h01) begin n_fail++; $display("FAIL first_pc got %h want 01", pc); end
        n_cmp++; if (issued_count !== 8'd1) begin n_fail++; $display("FAIL first_count got %0d want 1", issued_count); end
    endtask

    task automatic test_sequential();
        logic [10:0] exp_instr [1:4];
        exp_instr[1] = 11'h002; exp_instr[2] = 11'h003; exp_instr[3] = 11'h004; exp_instr[4] = 11'h005;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++; if (id_instr !== exp_instr[i]) begin n_fail++; $display("FAIL seq_instr i%0d got %h want %h", i, id_instr, exp_instr[i]); end
            n_cmp++; if (id_pc !== 8'(i)) begin n_fail++; $display("FAIL seq_idpc i%0d got %h want %h", i, id_pc, 8'(i)); end
            n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid i%0d got %b want 1", i, id_valid); end
        end
        n_cmp++; if (issued_count !== 8'd5) begin n_fail++; $display("FAIL seq_count got %0d want 5", issued_count); end
        n_cmp++; if (pc !== 8'h05) begin n_fail++; $display("FAIL seq_pc got %h want 05", pc); end
    endtask

    task automatic test_branch();
        // Plain redirect from PC=5.
        branch_taken = 1'b1; branch_target = 8'h20;
        step();
        branch_taken = 1'b0;
        n_cmp++; if (pc !== 8'h20) begin n_fail++; $display("FAIL br_pc got %h want 20", pc); end
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid got %b want 0", id_valid); end
        n_cmp++; if (id_instr !== 11'h000) begin n_fail++; $display("FAIL br_bubble got %h want 000", id_instr); end
        n_cmp++; if (issued_count !== 8'd5) begin n_fail++; $display("FAIL br_count got %0d want 5", issued_count); end
        step();
        n_cmp++; if (id_instr !== 11'h021) begin n_fail++; $display("FAIL br_instr got %h want 021", id_instr); end
        n_cmp++; if (id_pc !== 8'h20) begin n_fail++; $display("FAIL br_idpc got %h want 20", id_pc); end
        n_cmp++; if (issued_count !== 8'd6) begin n_fail++; $display("FAIL br_count2 got %0d want 6", issued_count); end
        // Redirect together with stall.
        branch_taken = 1'b1; stall = 1'b1; branch_target = 8'h20;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        n_cmp++; if (pc !== 8'h20) begin n_fail++; $display("FAIL brst_pc got %h want 20", pc); end
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL brst_valid got %b want 0", id_valid); end
        step();
        n_cmp++; if (id_instr !== 11'h021) begin n_fail++; $display("FAIL brst_instr got %h want 021", id_instr); end
        n_cmp++; if (id_pc !== 8'h20) begin n_fail++; $display("FAIL brst_idpc got %h want 20", id_pc); end
        // Out-of-range target is masked.
        branch_taken = 1'b1; branch_target = 8'hC5;
        step();
        branch_taken = 1'b0;
        n_cmp++; if (pc !== 8'h45) begin n_fail++; $display("FAIL brmask_pc got %h want 45", pc); end
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL brmask_valid got %b want 0", id_valid); end
        step();
        n_cmp++; if (id_instr !== 11'h046) begin n_fail++; $display("FAIL brmask_instr got %h want 046", id_instr); end
        n_cmp++; if (id_pc !== 8'h45) begin n_fail++; $display("FAIL brmask_idpc got %h want 45", id_pc); end
        n_cmp++; if (issued_count !== 8'd8) begin n_fail++; $display("FAIL brmask_count got %0d want 8", issued_count); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (pc !== 8'h03) begin n_fail++; $display("FAIL st_pre_pc got %h want 03", pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc !== 8'h03) begin n_fail++; $display("FAIL st_pc cyc%0d got %h want 03", i, pc); end
            n_cmp++; if (id_instr !== 11'h003) begin n_fail++; $display("FAIL st_instr cyc%0d got %h want 003", i, id_instr); end
            n_cmp++; if (id_pc !== 8'h02) begin n_fail++; $display("FAIL st_idpc cyc%0d got %h want 02", i, id_pc); end
            n_cmp++; if (issued_count !== 8'd3) begin n_fail++; $display("FAIL st_count cyc%0d got %0d want 3", i, issued_count); end
        end
        stall = 1'b0;
        step();
        n_cmp++; if (id_instr !== 11'h004) begin n_fail++; $display("FAIL st_rel_instr got %h want 004", id_instr); end
        n_cmp++; if (id_pc !== 8'h03) begin n_fail++; $display("FAIL st_rel_idpc got %h want 03", id_pc); end
        n_cmp++; if (issued_count !== 8'd4) begin n_fail++; $display("FAIL st_rel_count got %0d want 4", issued_count); end
    endtask

    task automatic test_wrap_saturate();
        // From PC=4,count=4: 250 normal cycles leave PC=126, count=254.
        for (int i = 0; i < 250; i++) step();
        n_cmp++; if (pc !== 8'd126) begin n_fail++; $display("FAIL wr_pc126 got %0d want 126", pc); end
        n_cmp++; if (issued_count !== 8'd254) begin n_fail++; $display("FAIL wr_count254 got %0d want 254", issued_count); end
        step();
        n_cmp++; if (pc !== 8'd127) begin n_fail++; $display("FAIL wr_pc127 got %0d want 127", pc); end
        n_cmp++; if (issued_count !== 8'd255) begin n_fail++; $display("FAIL wr_count255 got %0d want 255", issued_count); end
        n_cmp++; if (id_instr !== 11'h07F) begin n_fail++; $display("FAIL wr_instr126 got %h want 07f", id_instr); end
        step();
        n_cmp++; if (pc !== 8'd0) begin n_fail++; $display("FAIL wr_pc0 got %0d want 0", pc); end
        n_cmp++; if (id_pc !== 8'd127) begin n_fail++; $display("FAIL wr_idpc127 got %0d want 127", id_pc); end
        n_cmp++; if (id_instr !== 11'h080) begin n_fail++; $display("FAIL wr_instr127 got %h want 080", id_instr); end
        n_cmp++; if (issued_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold1 got %0d want 255", issued_count); end
        step();
        n_cmp++; if (pc !== 8'd1) begin n_fail++; $display("FAIL wr_pc1 got %0d want 1", pc); end
        n_cmp++; if (id_pc !== 8'd0) begin n_fail++; $display("FAIL wr_idpc0 got %0d want 0", id_pc); end
        n_cmp++; if (issued_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold2 got %0d want 255", issued_count); end
    endtask

    task automatic test_reset_midop();
        branch_taken = 1'b1; branch_target = 8'h40;
        step();
        n_cmp++; if (pc !== 8'h40) begin n_fail++; $display("FAIL mid_pre_pc got %h want 40", pc); end
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h10;
        step();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL mid_pc got %h want 00", pc); end
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", id_valid); end
        n_cmp++; if (issued_count !== 8'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", issued_count); end
        step();
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_boot_valid got %b want 0", id_valid); end
        n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL mid_boot_pc got %h want 00", pc); end
        step();
        n_cmp++; if (id_instr !== 11'h001) begin n_fail++; $display("FAIL mid_instr got %h want 001", id_instr); end
        n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid2 got %b want 1", id_valid); end
        n_cmp++; if (issued_count !== 8'd1) begin n_fail++; $display("FAIL mid_count2 got %0d want 1", issued_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 128; i++) imem[i] = 11'(i + 1);
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap_saturate();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 11-bit RISC processor; sits directly upstream of imem and the decode/control logic.
- Owns the 8-bit PC, which drives imem address `a` combinationally, and captures imem `rd` into an IF/ID register.
- Handles decode stalls and taken-branch (Beq) redirects with bubble insertion.
- Keeps a saturating count of issued instructions for debug and bench checks.

Parameters:
- PC_WIDTH, 8: PC and branch-target width.
- INSTR_WIDTH, 11: instruction width.
- RESET_PC, 0: PC value loaded on reset.
- PC_LIMIT, 128: imem depth. Must be a power of two and no larger than 2^PC_WIDTH. PC wraps at this value.
- NOP_INSTR, 11'b000_0000_0000: encoding placed in id_instr for a bubble.
- CNT_WIDTH, 8: width of issued_count.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high.
- stall, input, 1: decode cannot accept; hold PC and IF/ID.
- branch_taken, input, 1: redirect fetch (Beq resolved true).
- branch_target, input, PC_WIDTH: redirect address.
- Instr, input, INSTR_WIDTH: imem read data for the current PC.
- PC, output, PC_WIDTH: fetch address to imem (registered).
- id_instr, output, INSTR_WIDTH: IF/ID instruction.
- id_pc, output, PC_WIDTH: PC of id_instr.
- id_valid, output, 1: id_instr is a real instruction (0 means bubble).
- issued_count, output, CNT_WIDTH: number of valid instructions delivered to ID.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high; it is sampled only on the posedge of clk.
- Reset values:
  - PC = RESET_PC.
  - id_instr = NOP_INSTR, id_pc = 0, id_valid = 0.
  - issued_count = 0.
  - FSM = BOOT.
- FSM has two states, BOOT and RUN.
- BOOT lasts exactly one cycle after reset deasserts:
  - IF/ID stays a bubble.
  - PC does not advance.
  - Next state is RUN unconditionally; branch_taken and stall are ignored in BOOT.
  - This gives imem one full cycle to present Instr for RESET_PC.
- RUN, per-cycle priority (highest first):
  1. reset: apply reset values and go to BOOT, even mid-stall or mid-branch.
  2. branch_taken: PC <= branch_target & (PC_LIMIT-1); IF/ID <= bubble (id_valid=0, id_instr=NOP_INSTR, id_pc=0). This applies even when stall=1, because a redirect overrides the stall.
  3. stall: PC, id_instr, id_pc, id_valid and issued_count all hold.
  4. Normal:
     - id_instr <= Instr, id_pc <= PC, id_valid <= 1.
     - PC <= (PC + 1) & (PC_LIMIT-1).
     - issued_count increments.
- Latency: the instruction at address A appears on id_instr one posedge after PC==A with no stall and no branch.
- Throughput: one instruction per cycle.
- Wrap-around: PC == PC_LIMIT-1 (127) goes to 0 on the next normal advance. No error flag is raised.
- Out-of-range target: branch_target >= PC_LIMIT is masked, not rejected.
- issued_count saturates at 2^CNT_WIDTH-1 and never wraps.
- Bubbles and stalls never increment issued_count.
- Instr is sampled only on non-stall, non-branch RUN cycles. X on Instr at other times must not propagate to id_instr.
- Outputs are purely registered; no combinational path from any input to any output.

Test Plan:
- Reset/boot: hold reset for 2 cycles, then release.
  - Required: PC=0 and id_valid=0 during reset and during the BOOT cycle.
  - Next posedge: id_instr=imem[0], id_pc=0, id_valid=1, PC=1, issued_count=1.
- Sequential run: imem[0..4] = 11'h001..11'h005, no stall or branch.
  - Required: id_instr is 001, 002, 003, 004, 005 on consecutive cycles, id_pc is 0..4, issued_count=5.
- Stall: assert stall for 3 cycles while PC=3.
  - Required: PC stays 3, id_instr/id_pc stay at the PC=2 entry, issued_count is unchanged.
  - After release: id_instr=imem[3] on the next cycle.
- Branch: assert branch_taken with branch_target=8'h20 at PC=5.
  - Required: next cycle PC=0x20 and id_valid=0.
  - Following cycle: id_instr=imem[32], id_pc=0x20.
  - Repeat with stall=1 at the same time: same result.
  - Repeat with target 8'hC5: PC=0x45.
- Wrap and saturation: run from PC=126 with CNT_WIDTH preloaded near its limit via a long run.
  - Required: PC sequence is 126, 127, 0, 1.
  - issued_count reaches 255 and holds at 255.
- Reset mid-operation: assert reset while stall=1 and branch_taken=1 at PC=0x40.
  - Required: next posedge PC=0, id_valid=0, issued_count=0.
  - Then exactly one BOOT bubble cycle before id_instr=imem[0].
